// File: rtl/sr_ff_driver_if.sv
// Request handshake between a requester and sr_ff_driver.
//   req_valid : requester has a target value on req_data
//   req_ready : driver is idle and will latch req_data on this edge
//   req_data  : target value for the external SR flip-flop bank
// A transfer happens on a rising edge where req_valid && req_ready.
// While req_valid=1 and req_ready=0, the requester keeps req_data stable.
// req_ready never depends on req_valid.
interface sr_ff_driver_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/sr_ff_driver.sv
// sr_ff_driver: writes a target value into an external bank of SR flip-flops.
// For each bit it drives S or R only where the bank differs from the target.
// It then reads the bank back and re-drives up to MAX_RETRY times.
// It reports done when the bank matches the target, and err when it never does.
//
// Ports
//   CLK, RST   : clock and synchronous active-high reset
//   req        : request handshake (slave side; see sr_ff_driver_if)
//   S, R       : registered set and reset drives to the bank
//   Q_in       : readback of the bank's Q outputs
//   busy       : registered; high whenever the FSM is not IDLE
//   done, err  : registered one-cycle completion pulses
//   retries    : re-drives used by the last completed request, saturating at 3
//   state_dbg  : current FSM state (0 = IDLE, 1 = DRIVE, 2 = CHECK)
//
// Timing for a first-try success with the handshake in cycle 0:
//   cycle 1 = DRIVE (S/R valid), cycle 2 = CHECK, cycle 3 = done and req_ready.
module sr_ff_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             CLK,
  input  logic             RST,
  sr_ff_driver_if.slave    req,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] Q_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       retries,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(MAX_RETRY);

  state_t           state;
  logic [WIDTH-1:0] tgt;
  logic [7:0]       cnt;
  logic [1:0]       cnt_sat;

  assign req.req_ready = (state == ST_IDLE);
  assign state_dbg     = state;

  // retries is only 2 bits wide, so larger counts are clipped to 3.
  assign cnt_sat = (cnt > 8'd3) ? 2'd3 : cnt[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      S       <= '0;
      R       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      retries <= 2'd0;
      tgt     <= '0;
      cnt     <= 8'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req.req_valid) begin
            tgt   <= req.req_data;
            cnt   <= 8'd0;
            // Excite only the bits that differ from the target, so S and R
            // can never both be high on the same bit.
            S     <= req.req_data & ~Q_in;
            R     <= ~req.req_data & Q_in;
            state <= ST_DRIVE;
            busy  <= 1'b1;
          end
        end
        ST_DRIVE: begin
          S     <= '0;
          R     <= '0;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (Q_in == tgt) begin
            done    <= 1'b1;
            retries <= cnt_sat;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end else if (cnt < CNT_MAX) begin
            cnt   <= cnt + 8'd1;
            S     <= tgt & ~Q_in;
            R     <= ~tgt & Q_in;
            state <= ST_DRIVE;
          end else begin
            err     <= 1'b1;
            retries <= cnt_sat;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          S     <= '0;
          R     <= '0;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_ff_driver.sv
// Directed bench for sr_ff_driver with a behavioural SR flip-flop bank.
// The bank can be told to ignore its first N non-zero drives, so that the
// retry and error paths can be exercised.
module tb_sr_ff_driver;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic [W-1:0] S, R, Q_in;
  logic         busy, done, err;
  logic [1:0]   retries;
  logic [1:0]   state_dbg;

  sr_ff_driver_if #(.WIDTH(W)) req_if ();

  sr_ff_driver #(.WIDTH(W), .MAX_RETRY(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req_if.slave),
    .S         (S),
    .R         (R),
    .Q_in      (Q_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .retries   (retries),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- bank model ----------------
  logic [W-1:0] bank_q = '0;
  logic [W-1:0] bank_load_val;
  logic         bank_load_en;
  int           ignore_drives;
  int           drive_cnt = 0;

  assign Q_in = bank_q;

  always @(posedge CLK) begin
    if (bank_load_en) begin
      bank_q    <= bank_load_val;
      drive_cnt <= 0;
    end else if ((S | R) != '0) begin
      drive_cnt <= drive_cnt + 1;
      if (drive_cnt >= ignore_drives)
        bank_q <= (bank_q & ~R) | S;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every DRIVE cycle must match the next expected {S,R} pair. The S/R
  // exclusivity and done/err exclusivity are checked on every cycle.
  always @(negedge CLK) begin
    logic [15:0] e;
    check("sr_both_high", 32'(S & R), 32'd0);
    check("done_and_err", 32'(done & err), 32'd0);
    if (state_dbg == 2'd1) begin
      if (exp_q.size() == 0) begin
        check("drive_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("drive_S", 32'(S), 32'(e[15:8]));
        check("drive_R", 32'(R), 32'(e[7:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_bank(input logic [W-1:0] v, input int ign);
    bank_load_val = v;
    ignore_drives = ign;
    bank_load_en  = 1'b1;
    tick();
    bank_load_en  = 1'b0;
  endtask

  // Presents a request in cycle 0 and returns in cycle 1, the first DRIVE.
  task automatic do_req(input logic [W-1:0] d);
    req_if.req_valid = 1'b1;
    req_if.req_data  = d;
    tick();
    req_if.req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  initial begin
    int n_drv;
    logic done_seen;
    RST              = 1'b1;
    req_if.req_valid = 1'b1;
    req_if.req_data  = 8'h77;
    bank_load_en     = 1'b0;
    bank_load_val    = '0;
    ignore_drives    = 0;
    tick();
    tick();
    // A request held during reset must not be accepted.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_if.req_ready), 32'd1);
    check("rst_S", 32'(S), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_retries", 32'(retries), 32'd0);
    req_if.req_valid = 1'b0;
    RST = 1'b0;
    load_bank(8'h00, 0);

    // First-try success: Q=00, request A5.
    exp_q.push_back({8'hA5, 8'h00});
    do_req(8'hA5);
    check("ft_S_c1", 32'(S), 32'hA5);
    check("ft_R_c1", 32'(R), 32'h00);
    check("ft_busy_c1", 32'(busy), 32'd1);
    check("ft_ready_c1", 32'(req_if.req_ready), 32'd0);
    tick();
    check("ft_S_c2", 32'(S), 32'h00);
    check("ft_done_c2", 32'(done), 32'd0);
    tick();
    check("ft_done_c3", 32'(done), 32'd1);
    check("ft_retries", 32'(retries), 32'd0);
    check("ft_ready_c3", 32'(req_if.req_ready), 32'd1);
    check("ft_busy_c3", 32'(busy), 32'd0);
    tick();
    check("ft_done_c4", 32'(done), 32'd0);

    // Mixed excitation: Q=F0, request 3C.
    load_bank(8'hF0, 0);
    exp_q.push_back({8'h0C, 8'hC0});
    do_req(8'h3C);
    check("mx_S", 32'(S), 32'h0C);
    check("mx_R", 32'(R), 32'hC0);
    tick();
    tick();
    check("mx_done", 32'(done), 32'd1);
    check("mx_bank", 32'(Q_in), 32'h3C);

    // Retry: the bank ignores the first drive.
    load_bank(8'h00, 1);
    exp_q.push_back({8'h55, 8'h00});
    exp_q.push_back({8'h55, 8'h00});
    do_req(8'h55);
    tick();
    tick();
    check("rt_S_redrive", 32'(S), 32'h55);
    check("rt_done_early", 32'(done), 32'd0);
    tick();
    tick();
    check("rt_done", 32'(done), 32'd1);
    check("rt_retries", 32'(retries), 32'd1);

    // Target already equal to the bank: DRIVE with S=R=0, done 3 cycles later.
    tick();
    exp_q.push_back({8'h00, 8'h00});
    do_req(8'h55);
    check("eq_busy", 32'(busy), 32'd1);
    check("eq_SR", 32'({S, R}), 32'd0);
    tick();
    tick();
    check("eq_done", 32'(done), 32'd1);
    check("eq_retries", 32'(retries), 32'd0);

    // Back-to-back: a second request is held through the done cycle.
    load_bank(8'h00, 0);
    exp_q.push_back({8'h0F, 8'h00});
    exp_q.push_back({8'hF0, 8'h0F});
    do_req(8'h0F);
    req_if.req_valid = 1'b1;
    req_if.req_data  = 8'hF0;
    tick();
    check("bb_ready_c2", 32'(req_if.req_ready), 32'd0);
    tick();
    check("bb_done_c3", 32'(done), 32'd1);
    check("bb_ready_c3", 32'(req_if.req_ready), 32'd1);
    tick();
    req_if.req_valid = 1'b0;
    check("bb_S_c4", 32'(S), 32'hF0);
    check("bb_R_c4", 32'(R), 32'h0F);
    check("bb_busy_c4", 32'(busy), 32'd1);
    tick();
    tick();
    check("bb_done_c6", 32'(done), 32'd1);

    // Error: bank stuck at 00, request FF. Expect 4 drives and then err.
    load_bank(8'h00, 1000);
    repeat (4) exp_q.push_back({8'hFF, 8'h00});
    n_drv     = 0;
    done_seen = 1'b0;
    do_req(8'hFF);
    for (int i = 1; i < 9; i++) begin
      if (S == 8'hFF) n_drv++;
      done_seen |= done;
      check("er_err_early", 32'(err), 32'd0);
      tick();
    end
    check("er_err", 32'(err), 32'd1);
    check("er_retries", 32'(retries), 32'd3);
    check("er_drives", 32'(n_drv), 32'd4);
    check("er_done_seen", 32'(done_seen | done), 32'd0);
    check("er_ready", 32'(req_if.req_ready), 32'd1);
    tick();
    check("er_err_pulse", 32'(err), 32'd0);
    check("er_busy", 32'(busy), 32'd0);

    // Reset during DRIVE.
    load_bank(8'h00, 0);
    exp_q.push_back({8'h33, 8'h00});
    do_req(8'h33);
    check("rm_S_drive", 32'(S), 32'h33);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rm_S", 32'(S), 32'd0);
    check("rm_R", 32'(R), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_retries", 32'(retries), 32'd0);
    check("rm_ready", 32'(req_if.req_ready), 32'd1);
    repeat (4) begin
      tick();
      check("rm_no_done", 32'(done), 32'd0);
      check("rm_no_err", 32'(err), 32'd0);
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_ff_driver.md
SR_FF_DRIVER -- requirements
Module: sr_ff_driver

Interface
REQ-001 Parameter WIDTH, default 8; number of external SR flip-flop bits driven and read back.
REQ-002 Parameter MAX_RETRY, default 3; number of re-drive attempts after the first drive before an error is reported.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  write request; the requester holds req_data stable while req_valid=1 and req_ready=0.
REQ-006 req_ready  output  1  block can accept a request; combinational, equals (state==IDLE).
REQ-007 req_data  input  WIDTH  target value for the flip-flop bank.
REQ-008 S  output  WIDTH  set drive to the external SR flip-flop bank; registered.
REQ-009 R  output  WIDTH  reset drive to the external SR flip-flop bank; registered.
REQ-010 Q_in  input  WIDTH  readback of the bank's Q outputs.
REQ-011 busy  output  1  high in every state except IDLE; registered.
REQ-012 done  output  1  one-cycle pulse when the readback matches the target; registered.
REQ-013 err  output  1  one-cycle pulse when retries are exhausted without a match; registered.
REQ-014 retries  output  2  number of re-drives used by the last completed request; saturates at 3; registered.

Function
REQ-015 FSM states: IDLE, DRIVE, CHECK; the encoding is free.
REQ-016 IDLE: a handshake occurs when req_valid=1 and req_ready=1.
- On the handshake, the block latches req_data into tgt and clears the retry counter.
- On the same edge it loads S <= req_data & ~Q_in and R <= ~req_data & Q_in, and moves to DRIVE.
REQ-017 DRIVE lasts exactly one cycle. S and R hold their loaded values for that cycle, and the state then moves to CHECK.
REQ-018 On the DRIVE->CHECK edge, S and R SHALL be cleared to all zeros. They stay zero in CHECK and IDLE.
REQ-019 CHECK lasts one cycle and compares Q_in against tgt.
- Match: done pulses on the next cycle, retries is updated with the counter, and the state returns to IDLE.
- Mismatch with counter < MAX_RETRY: the counter increments, S and R are reloaded from tgt and the current Q_in as in REQ-016, and the state returns to DRIVE.
- Mismatch with counter == MAX_RETRY: err pulses on the next cycle, retries is updated (saturated), and the state returns to IDLE.
REQ-020 Latency for a first-try success is fixed. With the handshake in cycle 0, S and R are valid in cycle 1, CHECK is in cycle 2, done=1 in cycle 3, and req_ready=1 in cycle 3.
REQ-021 Each bit that already equals its target SHALL have S=0 and R=0 during DRIVE.
REQ-022 S[i] and R[i] SHALL never both be 1 in any cycle (illegal SR input). The bench asserts this on every cycle.
REQ-023 done and err SHALL never both be 1 in the same cycle.
REQ-024 A request presented in the cycle that done or err is high SHALL be accepted, because the state is already IDLE.
REQ-025 req_valid is ignored while the state is not IDLE. No request is buffered or dropped silently, because req_ready=0 during that time.
REQ-026 A target equal to the current Q_in still passes through DRIVE with S=R=0. done then pulses 3 cycles after the handshake.

Reset
REQ-027 When RST=1 at a rising edge, the block SHALL go to IDLE and set S=0, R=0, busy=0, done=0, err=0, retries=0, tgt=0 and counter=0. This applies from every state.
REQ-028 RST has priority over the handshake and the FSM. A request presented in the same cycle as RST is not accepted.
REQ-029 RST asserted during DRIVE SHALL clear S and R on that edge, with no done or err pulse afterwards.

Verification
REQ-030 First-try success: bank model Q=0x00, request 0xA5. Expected: S=0xA5, R=0x00 in cycle 1; done=1 and retries=0 in cycle 3.
REQ-031 Mixed excitation: Q=0xF0, request 0x3C. Expected: S=0x0C and R=0xC0 in DRIVE, then done.
REQ-032 Retry path: the bank model ignores the first drive, then Q_in=0x55. Expected: a second DRIVE with S=0x55, then done with retries=1.
REQ-033 Error path: bank stuck at 0x00, request 0xFF. Expected: 4 DRIVE cycles, err=1, retries=3, done never asserted, then IDLE.
REQ-034 Back-to-back: a second request is held on req_valid through the done cycle. Expected: it is accepted in the done cycle, and S/R for it appear in the next cycle.
REQ-035 Reset mid-operation: RST=1 in a DRIVE cycle. Expected: S=R=0 and busy=0 on the next cycle, with no done or err.
